alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational ALU. Adds registered output, valid/ready flow control on both sides, status flags, an error flag, and an iterative unsigned multiplier.
- Sits between the instruction/stimulus driver and the result consumer, driven from the shared ALU interface clock.
- One operation is in flight at a time. Single-cycle ops sustain one result per cycle when the sink is ready.

---
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_pipe.sv | 188 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bundle for alu_pipe.
// The master drives operands and result acceptance; the slave (the ALU) drives results.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       Op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic [3:0]       Flags;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, Op, in_valid, out_ready,
        input  in_ready, Result, ResultHi, Flags, out_err, out_valid
    );

    modport slave (
        input  A, B, Op, in_valid, out_ready,
        output in_ready, Result, ResultHi, Flags, out_err, out_valid
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with an iterative shift-add unsigned multiplier.
// Define ALU_SAT_EN to make ADD/SUB saturate as signed instead of wrapping.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input logic   clk,
    input logic   reset,
    alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic               ovalid_q, ovalid_d;

    logic               in_ready;
    logic               accept;
    logic               mul_last;
    logic [2*WIDTH-1:0] step_acc;

    logic [WIDTH:0]     add_ext, sub_ext;
    logic               add_v, sub_v;
    logic [WIDTH-1:0]   sat_val;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err;
    logic [3:0]         alu_flags;

    assign accept   = bus.in_valid && in_ready;
    assign mul_last = (cnt_q == SHW'(WIDTH - 1));
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign add_ext = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_ext = {1'b0, bus.A} - {1'b0, bus.B};
    assign add_v   = (bus.A[MSB] == bus.B[MSB]) && (add_ext[MSB] != bus.A[MSB]);
    assign sub_v   = (bus.A[MSB] != bus.B[MSB]) && (sub_ext[MSB] != bus.A[MSB]);
    // Any signed overflow of A+B or A-B goes in the direction of A's sign.
    assign sat_val = bus.A[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign shamt   = bus.B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.Op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = add_v;
`ifdef ALU_SAT_EN
                if (add_v) alu_res = sat_val;
`endif
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = sub_v;
`ifdef ALU_SAT_EN
                if (sub_v) alu_res = sat_val;
`endif
            end
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_NOT: alu_res = ~bus.A;
            OP_SHL: alu_res = bus.A << shamt;
            OP_SHR: alu_res = bus.A >> shamt;
            OP_SRA: alu_res = WIDTH'($signed(bus.A) >>> shamt);
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
        alu_flags = alu_err ? 4'b0000 : {alu_res[MSB], alu_v, alu_c, alu_res == '0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && bus.Op == OP_MUL) state_d = MUL;
            MUL:     if (mul_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && (!ovalid_q || bus.out_ready);
    end

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_d    = res_q;
        hi_d     = hi_q;
        flags_d  = flags_q;
        err_d    = err_q;
        ovalid_d = ovalid_q;
        if (state_q == MUL) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (mul_last) begin
                cnt_d    = '0;
                res_d    = step_acc[WIDTH-1:0];
                hi_d     = step_acc[2*WIDTH-1:WIDTH];
                flags_d  = {step_acc[2*WIDTH-1], 1'b0,
                            step_acc[2*WIDTH-1:WIDTH] != '0, step_acc == '0};
                err_d    = 1'b0;
                ovalid_d = 1'b1;
            end
        end else begin
            if (ovalid_q && bus.out_ready) ovalid_d = 1'b0;
            if (accept) begin
                if (bus.Op == OP_MUL) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    res_d    = alu_res;
                    hi_d     = '0;
                    flags_d  = alu_flags;
                    err_d    = alu_err;
                    ovalid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.Result    = res_q;
    assign bus.ResultHi  = hi_q;
    assign bus.Flags     = flags_q;
    assign bus.out_err   = err_q;
    assign bus.out_valid = ovalid_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_pipe;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic [3:0] fl, output logic err);
        int ua, ub, sa, sb, s, r, sh, smax, smin;
        logic n, v, c, z;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        sh = ub % W;
        lo = '0; hi = '0; v = 0; c = 0; err = 0; r = 0;
        case (op)
            4'd0: begin
                r = ua + ub; c = (r >= (1 << W));
                s = sa + sb; v = (s > smax) || (s < smin);
`ifdef ALU_SAT_EN
                if (v) r = (s > smax) ? smax : smin;
`endif
            end
            4'd1: begin
                r = ua - ub; c = (ua < ub);
                s = sa - sb; v = (s > smax) || (s < smin);
`ifdef ALU_SAT_EN
                if (v) r = (s > smax) ? smax : smin;
`endif
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~ua;
            4'd6: r = ua << sh;
            4'd7: r = ua >> sh;
            4'd8: r = sa >>> sh;
            4'd9: r = ua * ub;
            default: err = 1;
        endcase
        lo = W'(r);
        if (op == 4'd9) begin
            hi = W'(r >> W);
            z = (r == 0);
            n = hi[W-1];
            c = (hi != 0);
        end else begin
            z = (lo == 0);
            n = lo[W-1];
        end
        fl = err ? 4'b0000 : {n, v, c, z};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] lo, hi;
        logic [3:0]   fl;
        logic         err;
        model(op, a, b, lo, hi, fl, err);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, ".res"},   64'(bus.Result),    64'(lo));
        check({tag, ".hi"},    64'(bus.ResultHi),  64'(hi));
        check({tag, ".flags"}, 64'(bus.Flags),     64'(fl));
        check({tag, ".err"},   64'(bus.out_err),   64'(err));
    endtask

    task automatic single(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Op = op; bus.A = a; bus.B = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        check({tag, ".rdy"}, 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        check_out(tag, op, a, b);
    endtask

    task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Op = 4'd9; bus.A = a; bus.B = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        check({tag, ".rdy"}, 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < int'(W); k++) begin
            check({tag, ".busy"}, 64'({bus.in_ready, bus.out_valid}), 64'(0));
            bus.A = W'($urandom); bus.B = W'($urandom); bus.Op = 4'(1);
            tick();
        end
        check_out(tag, 4'd9, a, b);
    endtask

    initial begin
        logic [3:0] op;
        reset = 1'b0;
        bus.A = '0; bus.B = '0; bus.Op = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst.valid", 64'(bus.out_valid), 64'(0));
        check("rst.res",   64'(bus.Result),    64'(0));
        check("rst.hi",    64'(bus.ResultHi),  64'(0));
        check("rst.flags", 64'(bus.Flags),     64'(0));
        check("rst.err",   64'(bus.out_err),   64'(0));
        check("rst.rdy",   64'(bus.in_ready),  64'(1));
        tick();

        single("add7f", 4'd0, 8'h7F, 8'h01);
`ifdef ALU_SAT_EN
        check("add7f.direct", 64'({bus.Flags, bus.Result}), 64'({4'b0100, 8'h7F}));
`else
        check("add7f.direct", 64'({bus.Flags, bus.Result}), 64'({4'b1100, 8'h80}));
`endif
        single("sub", 4'd1, 8'h00, 8'h01);
        check("sub.direct", 64'({bus.Flags, bus.Result}), 64'({4'b1010, 8'hFF}));
        single("shl", 4'd6, 8'h81, 8'h09);
        check("shl.direct", 64'({bus.Flags, bus.Result}), 64'({4'b0000, 8'h02}));
        single("sra0", 4'd8, 8'hA5, 8'h08);
        check("sra0.direct", 64'(bus.Result), 64'(8'hA5));
        mul("mulff", 8'hFF, 8'hFF);
        check("mulff.direct", 64'({bus.Flags, bus.ResultHi, bus.Result}),
              64'({4'b1010, 8'hFE, 8'h01}));
        single("ill", 4'hF, 8'h12, 8'h34);
        check("ill.direct", 64'({bus.out_err, bus.Flags, bus.ResultHi, bus.Result}),
              64'({1'b1, 4'b0000, 8'h00, 8'h00}));
        single("afterill", 4'd2, 8'hF0, 8'h3C);
        check("afterill.err", 64'(bus.out_err), 64'(0));
        tick();
        check("drain.valid", 64'(bus.out_valid), 64'(0));

        // Backpressure: held result, then drain and reload on the same edge.
        bus.out_ready = 1'b0;
        bus.Op = 4'd0; bus.A = 8'h01; bus.B = 8'h01; bus.in_valid = 1'b1;
        tick();
        bus.Op = 4'd4; bus.A = 8'h0F; bus.B = 8'hF0;
        #1;
        check("bp.rdy0", 64'(bus.in_ready), 64'(0));
        repeat (3) tick();
        check("bp.hold", 64'({bus.out_valid, bus.Result}), 64'({1'b1, 8'h02}));
        check("bp.rdy0b", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        #1;
        check("bp.rdy1", 64'(bus.in_ready), 64'(1));
        tick();
        bus.in_valid = 1'b0;
        check("bp.load", 64'({bus.out_valid, bus.Flags, bus.Result}),
              64'({1'b1, 4'b1000, 8'hFF}));
        tick();
        check("bp.drain", 64'(bus.out_valid), 64'(0));

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd9) mul("rmul", W'($urandom), W'($urandom));
            else            single("rop", op, W'($urandom), W'($urandom));
        end
        mul("rmul0", 8'h00, W'($urandom));
        mul("rmulx", W'($urandom), W'($urandom));

        // Reset in the middle of a multiply discards it.
        bus.Op = 4'd9; bus.A = 8'h0F; bus.B = 8'h0F; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("rstmul.valid", 64'(bus.out_valid), 64'(0));
        check("rstmul.res",   64'({bus.ResultHi, bus.Result, bus.Flags}), 64'(0));
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rstmul.none", 64'(bus.out_valid), 64'(0));
        end
        single("postrst", 4'd3, 8'h50, 8'h05);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
